// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle controller, the ALU decoder and the datapath muxes.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } mc_state_t;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_LW    = 4'b0001;
  localparam logic [3:0] OP_SW    = 4'b0010;
  localparam logic [3:0] OP_BEQ   = 4'b0011;
  localparam logic [3:0] OP_ADDI  = 4'b0100;
  localparam logic [3:0] OP_J     = 4'b0101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_TWO   = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
  } mc_ctrl_t;

endpackage

// File: rtl/mc_outdec.sv
// State-to-control-word decoder; only FETCH looks at mem_ready (IR/PC load on completion).
module mc_outdec
  import mc_pkg::*;
(
  input  mc_state_t st,
  input  logic      mem_ready,
  output mc_ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (st)
      S_FETCH: begin
        ctrl.memread = 1'b1;
        ctrl.alusrcb = SRCB_TWO;
        ctrl.irwrite = mem_ready;
        ctrl.pcwrite = mem_ready;
      end
      S_DECODE: ctrl.alusrcb = SRCB_IMMSH;
      S_MEMADR, S_ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl.iord    = 1'b1;
        ctrl.memread = 1'b1;
      end
      S_MEMWB: begin
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      S_MEMWR: begin
        ctrl.iord     = 1'b1;
        ctrl.memwrite = 1'b1;
      end
      S_EXEC: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.regdst   = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALUOP_SUB;
        ctrl.branch  = 1'b1;
        ctrl.pcsrc   = PCSRC_ALUOUT;
      end
      S_ADDIWB: ctrl.regwrite = 1'b1;
      S_JUMP: begin
        ctrl.pcsrc   = PCSRC_JUMP;
        ctrl.pcwrite = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle main controller: state register, next-state logic, optional perf counters.
// Optional feature macro: MC_CONTROLLER_PERF_EN (adds cycle_count / instr_count).
module mc_controller
  import mc_pkg::*;
#(
  parameter int n = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [n-13:0] opcode,
  input  logic          mem_ready,
  output logic          pcwrite,
  output logic          branch,
  output logic          iord,
  output logic          memread,
  output logic          memwrite,
  output logic          irwrite,
  output logic          regdst,
  output logic          memtoreg,
  output logic          regwrite,
  output logic          alusrca,
  output logic [1:0]    alusrcb,
  output logic [1:0]    pcsrc,
  output logic [1:0]    aluop,
  output logic          illegal_op,
`ifdef MC_CONTROLLER_PERF_EN
  output logic [31:0]   cycle_count,
  output logic [31:0]   instr_count,
`endif
  output logic [3:0]    state
);

  mc_state_t st, st_nx;
  mc_ctrl_t  ctrl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) st <= S_FETCH;
    else       st <= st_nx;
  end

  always_comb begin
    st_nx      = st;
    illegal_op = 1'b0;
    case (st)
      S_FETCH:  if (mem_ready) st_nx = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     st_nx = S_EXEC;
          OP_LW, OP_SW: st_nx = S_MEMADR;
          OP_BEQ:       st_nx = S_BRANCH;
          OP_ADDI:      st_nx = S_ADDIEX;
          OP_J:         st_nx = S_JUMP;
          default: begin
            st_nx      = S_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      // only lw/sw can reach MEMADR
      S_MEMADR: st_nx = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) st_nx = S_MEMWB;
      S_MEMWR:  if (mem_ready) st_nx = S_FETCH;
      S_EXEC:   st_nx = S_ALUWB;
      S_ADDIEX: st_nx = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: st_nx = S_FETCH;
      default:  st_nx = S_FETCH;
    endcase
  end

  mc_outdec u_outdec (
    .st        (st),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  assign {pcwrite, branch, iord, memread, memwrite, irwrite, regdst, memtoreg,
          regwrite, alusrca, alusrcb, pcsrc, aluop} = ctrl;
  assign state = st;

`ifdef MC_CONTROLLER_PERF_EN
  // an instruction retires on every return to FETCH, illegal ones included
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_count <= '0;
      instr_count <= '0;
    end else begin
      cycle_count <= cycle_count + 32'd1;
      if (st != S_FETCH && st_nx == S_FETCH) instr_count <= instr_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: per-cycle vector table through a scoreboard, plus reset corners.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] opcode;
  logic       mem_ready;
  logic       pcwrite, branch, iord, memread, memwrite, irwrite;
  logic       regdst, memtoreg, regwrite, alusrca, illegal_op;
  logic [1:0] alusrcb, pcsrc, aluop;
  logic [3:0] state;
`ifdef MC_CONTROLLER_PERF_EN
  logic [31:0] cycle_count, instr_count;
`endif

  mc_controller #(.n(16)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pcwrite(pcwrite), .branch(branch), .iord(iord), .memread(memread),
    .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst), .memtoreg(memtoreg),
    .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
    .aluop(aluop), .illegal_op(illegal_op),
`ifdef MC_CONTROLLER_PERF_EN
    .cycle_count(cycle_count), .instr_count(instr_count),
`endif
    .state(state)
  );

  always #5 clk = ~clk;

  // {pcwrite,branch,iord,memread,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca,alusrcb,pcsrc,aluop,illegal_op}
  localparam logic [17:0] W_F1   = 18'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
  localparam logic [17:0] W_F0   = 18'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
  localparam logic [17:0] W_DEC  = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
  localparam logic [17:0] W_DILL = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_1;
  localparam logic [17:0] W_MADR = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [17:0] W_MRD  = 18'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
  localparam logic [17:0] W_MWB  = 18'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
  localparam logic [17:0] W_MWR  = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
  localparam logic [17:0] W_EXEC = 18'b0_0_0_0_0_0_0_0_0_1_00_00_10_0;
  localparam logic [17:0] W_AWB  = 18'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
  localparam logic [17:0] W_BR   = 18'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
  localparam logic [17:0] W_IWB  = 18'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;
  localparam logic [17:0] W_JMP  = 18'b1_0_0_0_0_0_0_0_0_0_00_10_00_0;

  typedef struct {
    logic [3:0]  op;
    logic        mr;
    logic [3:0]  st;
    logic [17:0] w;
  } vec_t;

  typedef struct {
    int          idx;
    logic [3:0]  st;
    logic [17:0] w;
  } exp_t;

  vec_t vt[$];
  exp_t sb[$];
  int   ntest = 0;
  int   nfail = 0;

  function automatic logic [17:0] ctrl_word();
    return {pcwrite, branch, iord, memread, memwrite, irwrite, regdst, memtoreg,
            regwrite, alusrca, alusrcb, pcsrc, aluop, illegal_op};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntest++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] op, input logic mr, input logic [3:0] st, input logic [17:0] w);
    vec_t v;
    v.op = op; v.mr = mr; v.st = st; v.w = w;
    vt.push_back(v);
  endtask

  initial begin
    exp_t e;
    // R-type, zero wait
    add(4'h0,1,0,W_F1); add(4'h0,1,1,W_DEC); add(4'h0,1,6,W_EXEC); add(4'h0,1,7,W_AWB);
    // lw with two MEMRD wait cycles
    add(4'h1,1,0,W_F1); add(4'h1,1,1,W_DEC); add(4'h1,1,2,W_MADR);
    add(4'h1,0,3,W_MRD); add(4'h1,0,3,W_MRD); add(4'h1,1,3,W_MRD); add(4'h1,1,4,W_MWB);
    // beq
    add(4'h3,1,0,W_F1); add(4'h3,1,1,W_DEC); add(4'h3,1,8,W_BR);
    // illegal opcodes 1111 and 0110
    add(4'hF,1,0,W_F1); add(4'hF,1,1,W_DILL);
    add(4'h6,1,0,W_F1); add(4'h6,1,1,W_DILL);
    // sw with one FETCH wait and one MEMWR wait
    add(4'h2,0,0,W_F0); add(4'h2,1,0,W_F1); add(4'h2,1,1,W_DEC); add(4'h2,1,2,W_MADR);
    add(4'h2,0,5,W_MWR); add(4'h2,1,5,W_MWR);
    // addi
    add(4'h4,1,0,W_F1); add(4'h4,1,1,W_DEC); add(4'h4,1,9,W_MADR); add(4'h4,1,10,W_IWB);
    // j
    add(4'h5,1,0,W_F1); add(4'h5,1,1,W_DEC); add(4'h5,1,11,W_JMP);
    add(4'h0,1,0,W_F1);

    reset = 1'b1; mem_ready = 1'b1; opcode = 4'h0;
    repeat (2) @(negedge clk);
    chk("reset_state", {28'd0, state}, 32'd0);
    chk("reset_ctrl", {14'd0, ctrl_word()}, {14'd0, W_F1});
`ifdef MC_CONTROLLER_PERF_EN
    chk("reset_cycle_count", cycle_count, 32'd0);
    chk("reset_instr_count", instr_count, 32'd0);
`endif
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < vt.size(); i++) begin
      opcode    = vt[i].op;
      mem_ready = vt[i].mr;
      e.idx = i; e.st = vt[i].st; e.w = vt[i].w;
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      chk($sformatf("vec%0d_state", e.idx), {28'd0, state}, {28'd0, e.st});
      chk($sformatf("vec%0d_ctrl", e.idx), {14'd0, ctrl_word()}, {14'd0, e.w});
      @(posedge clk); #1;
    end
`ifdef MC_CONTROLLER_PERF_EN
    chk("instr_count_after_table", instr_count, 32'd8);
`endif

    // sw interrupted by reset while in MEMWR
    reset = 1'b1; opcode = 4'h2; mem_ready = 1'b1;
    @(negedge clk); reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 mem_ready = 1'b0;
    @(posedge clk); #1;
    chk("sw_in_memwr_state", {28'd0, state}, 32'd5);
    chk("sw_in_memwr_memwrite", {31'd0, memwrite}, 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("reset_mid_memwr_state", {28'd0, state}, 32'd0);
    chk("reset_mid_memwr_memwrite", {31'd0, memwrite}, 32'd0);
    chk("reset_mid_memwr_ctrl", {14'd0, ctrl_word()}, {14'd0, W_F0});
`ifdef MC_CONTROLLER_PERF_EN
    chk("reset_mid_cycle_count", cycle_count, 32'd0);
    chk("reset_mid_instr_count", instr_count, 32'd0);
`endif
    @(negedge clk);
    chk("reset_held_state", {28'd0, state}, 32'd0);
    reset = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    chk("post_reset_decode", {28'd0, state}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle main controller for the 16-bit RISC core. It sequences the shared datapath (single ALU, single memory port, register file, PC/IR registers) through fetch, decode, execute, memory and writeback states. It drives the 2-bit `aluop` consumed by the ALU decoder and stalls on a memory-ready handshake. It sits beside the ALU decoder inside the core's control unit.

## Interface
- `n`, default 16: datapath/instruction width; only `n`=16 is supported.
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  asynchronous, active-high; forces state to FETCH.
- `opcode`  input  4  `instr[15:12]` from the IR.
- `mem_ready`  input  1  memory handshake; the access completes in any cycle where it is high.
- `pcwrite`  output  1  unconditional PC load.
- `branch`  output  1  PC load qualified by datapath zero flag.
- `iord`  output  1  memory address select: 0 = PC, 1 = ALUOut.
- `memread`  output  1  memory read request.
- `memwrite`  output  1  memory write request.
- `irwrite`  output  1  IR load.
- `regdst`  output  1  write register select: 0 = rt, 1 = rd.
- `memtoreg`  output  1  writeback select: 0 = ALUOut, 1 = MDR.
- `regwrite`  output  1  register file write.
- `alusrca`  output  1  ALU A select: 0 = PC, 1 = rs.
- `alusrcb`  output  2  ALU B select: 00 rt, 01 const 2, 10 sign-extended imm, 11 imm shifted left 1.
- `pcsrc`  output  2  PC source: 00 ALU result, 01 ALUOut, 10 jump target.
- `aluop`  output  2  00 add, 01 sub, 10 use funct.
- `illegal_op`  output  1  one-cycle pulse on an undefined opcode.
- `state`  output  4  current state, for debug.

## Operation
- Opcodes: 0000 R-type, 0001 lw, 0010 sw, 0011 beq, 0100 addi, 0101 j; all others are illegal.
- States, with 4-bit encoding and transitions:
  - FETCH(0): next DECODE.
  - DECODE(1): lw/sw go to MEMADR; R goes to EXEC; beq goes to BRANCH; addi goes to ADDIEX; j goes to JUMP; illegal goes to FETCH with `illegal_op`=1.
  - MEMADR(2): lw goes to MEMRD; sw goes to MEMWR.
  - MEMRD(3): next MEMWB.
  - MEMWB(4): next FETCH.
  - MEMWR(5): next FETCH.
  - EXEC(6): next ALUWB.
  - ALUWB(7): next FETCH.
  - BRANCH(8): next FETCH.
  - ADDIEX(9): next ADDIWB.
  - ADDIWB(10): next FETCH.
  - JUMP(11): next FETCH.
  - Encodings 12–15 are unreachable; if entered, go to FETCH with all outputs idle.
- FETCH, MEMRD and MEMWR hold state while `mem_ready`=0 and advance only when `mem_ready`=1.
- Outputs per state; any signal not listed is 0:
  - FETCH: `iord`=0, `memread`=1, `alusrca`=0, `alusrcb`=01, `aluop`=00, `pcsrc`=00. `irwrite` = `pcwrite` = `mem_ready`.
  - DECODE: `alusrca`=0, `alusrcb`=11, `aluop`=00 (branch target into ALUOut).
  - MEMADR, ADDIEX: `alusrca`=1, `alusrcb`=10, `aluop`=00.
  - MEMRD: `iord`=1, `memread`=1.
  - MEMWB: `regdst`=0, `memtoreg`=1, `regwrite`=1.
  - MEMWR: `iord`=1, `memwrite`=1 (held through the wait).
  - EXEC: `alusrca`=1, `alusrcb`=00, `aluop`=10.
  - ALUWB: `regdst`=1, `memtoreg`=0, `regwrite`=1.
  - BRANCH: `alusrca`=1, `alusrcb`=00, `aluop`=01, `branch`=1, `pcsrc`=01.
  - ADDIWB: `regdst`=0, `memtoreg`=0, `regwrite`=1.
  - JUMP: `pcsrc`=10, `pcwrite`=1.
- `regwrite`, `memwrite`, `pcwrite` and `branch` are never asserted together, except `pcwrite` with `irwrite` in FETCH.

## Timing
- State register updates on the rising edge of `clk`. Outputs decode combinationally from state; only FETCH outputs also depend on `mem_ready`.
- Reset values: state = FETCH, so `memread`=1, `alusrcb`=01, and every other output is 0 (`irwrite`/`pcwrite` still follow `mem_ready`).
- Reset deassertion takes effect at the first `clk` edge after it falls.
- Latency with zero wait states:
  - R and addi: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq and j: 3 cycles.
  - illegal opcode: 2 cycles.
- Each cycle of `mem_ready`=0 in FETCH, MEMRD or MEMWR adds exactly one cycle.
- Reset asserted mid-instruction: state returns to FETCH immediately (asynchronously). No write strobe may glitch high after reset asserts.

## Configuration
- `MC_CONTROLLER_PERF_EN` defined: adds outputs `cycle_count` [31:0] and `instr_count` [31:0], both reset to 0.
  - `cycle_count` increments every cycle that reset is low.
  - `instr_count` increments on each transition into FETCH from a non-FETCH state, including illegal opcodes.
  - Both wrap from 0xFFFF_FFFF to 0.
- Undefined: neither the ports nor the counters exist.

## Structure
- Package `mc_pkg`: state enum `mc_state_t` (4-bit, encodings above), opcode localparams, and the `aluop`, `alusrcb` and `pcsrc` encodings, shared with the ALU decoder and datapath.
- One natural sub-module, `mc_outdec`: combinational state-to-control-word decoder. The top holds the state register, next-state logic and optional counters.

## Test plan
- Reset held, then released with `mem_ready`=1 -> `state`=0, `memread`=1, `irwrite`=1, `pcwrite`=1, all others 0.
- R-type (opcode 0000), `mem_ready`=1 -> states 0,1,6,7,0 in consecutive cycles. `aluop`=10 in EXEC; `regwrite`=1 and `regdst`=1 in ALUWB only.
- lw (0001) with `mem_ready` low for 2 cycles in MEMRD -> MEMRD held 3 cycles with `iord`=1 throughout. MEMWB has `memtoreg`=1; total 7 cycles.
- beq (0011) -> states 0,1,8,0. In BRANCH: `aluop`=01, `branch`=1, `pcsrc`=01, `pcwrite`=0.
- Opcode 1111 -> DECODE then FETCH; `illegal_op` high for exactly one cycle; no `regwrite`/`memwrite` seen.
- sw with reset pulsed during MEMWR -> `memwrite` drops in the same cycle, `state`=0. With `MC_CONTROLLER_PERF_EN` defined, both counters read 0.
